// File: rtl/bmcp_recv.sv
// Receive half of the MCP clock-domain crossing: synchronizes the sender's toggle
// enable, captures the quiet data bus, and returns a toggle ack per consumed word.
module bmcp_recv #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          bclk,
  input  logic          brst,
  input  logic [DW-1:0] adata,
  input  logic          a_en,
  input  logic          bload,
  output logic [DW-1:0] bdata,
  output logic          bvalid,
  output logic          b_ack,
  output logic          berr,
  output logic [7:0]    bcnt
);

  localparam int unsigned CW = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   bpulse_c;
  logic [DW-1:0]          bdata_nxt;
  logic                   ack_nxt;
  logic                   err_nxt;
  logic [CW-1:0]          cnt_nxt;

  // a_en synchronizer plus one history flop; only the enable crosses through flops
  always_ff @(posedge bclk) begin
    if (brst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], a_en};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign bpulse_c = sync[SYNC_STAGES-1] ^ hist;

  // State and output registers
  always_ff @(posedge bclk) begin
    if (brst) begin
      state <= ST_EMPTY;
      bdata <= '0;
      b_ack <= 1'b0;
      berr  <= 1'b0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bdata <= bdata_nxt;
      b_ack <= ack_nxt;
      berr  <= err_nxt;
      bcnt  <= cnt_nxt;
    end
  end

  assign bvalid = (state == ST_VALID);

  // A word arriving while one is still held is dropped and flagged; bload still consumes
  always_comb begin
    state_nxt = state;
    bdata_nxt = bdata;
    ack_nxt   = b_ack;
    err_nxt   = berr;
    cnt_nxt   = bcnt;
    unique case (state)
      ST_EMPTY: begin
        if (bpulse_c) begin
          bdata_nxt = adata;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (bpulse_c) begin
          err_nxt = 1'b1;
        end
        if (bload) begin
          state_nxt = ST_EMPTY;
          ack_nxt   = ~b_ack;
          cnt_nxt   = bcnt + CW'(1);
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_bmcp_recv.sv
// Bench for bmcp_recv: delay-queue reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_bmcp_recv;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;

  logic          bclk;
  logic          brst;
  logic [DW-1:0] adata;
  logic          a_en;
  logic          bload;
  logic [DW-1:0] bdata;
  logic          bvalid;
  logic          b_ack;
  logic          berr;
  logic [7:0]    bcnt;

  int checks   = 0;
  int failures = 0;

  bmcp_recv #(.DW(DW), .SYNC_STAGES(SS)) dut (
    .bclk  (bclk),
    .brst  (brst),
    .adata (adata),
    .a_en  (a_en),
    .bload (bload),
    .bdata (bdata),
    .bvalid(bvalid),
    .b_ack (b_ack),
    .berr  (berr),
    .bcnt  (bcnt)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each a_en change seen at an edge becomes a capture event SS edges later
  int            pend[$];
  logic          m_prev  = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_ack   = 1'b0;
  logic          m_err   = 1'b0;
  int            m_cnt   = 0;

  // Observations of the DUT itself
  int            captures    = 0;
  int            ack_toggles = 0;
  logic          prev_valid  = 1'b0;
  logic          prev_ack    = 1'b0;
  logic [DW-1:0] rx[$];

  always begin
    bit pulse;
    @(posedge bclk);
    pulse = 1'b0;
    if (brst) begin
      pend.delete();
      m_prev = 1'b0; m_valid = 1'b0; m_data = '0;
      m_ack = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      for (int i = 0; i < pend.size(); i++) pend[i]--;
      if (pend.size() > 0 && pend[0] == 0) begin
        pulse = 1'b1;
        void'(pend.pop_front());
      end
      if (a_en != m_prev) pend.push_back(SS);
      m_prev = a_en;
      if (m_valid) begin
        if (pulse) m_err = 1'b1;
        if (bload) begin
          m_valid = 1'b0;
          m_ack   = ~m_ack;
          m_cnt   = (m_cnt + 1) % 256;
        end
      end else if (pulse) begin
        m_valid = 1'b1;
        m_data  = adata;
      end
    end
    #1;
    chk("m_bvalid", 32'(bvalid), 32'(m_valid));
    if (m_valid) chk("m_bdata", 32'(bdata), 32'(m_data));
    chk("m_b_ack", 32'(b_ack), 32'(m_ack));
    chk("m_berr", 32'(berr), 32'(m_err));
    chk("m_bcnt", 32'(bcnt), 32'(m_cnt));
    if (bvalid === 1'b1 && prev_valid !== 1'b1) begin
      captures++;
      rx.push_back(bdata);
    end
    if (b_ack !== prev_ack) ack_toggles++;
    prev_valid = bvalid;
    prev_ack   = b_ack;
  end

  // Sender-side 2-flop synchronizer of the ack
  logic ack_s1, ack_s2;
  always @(posedge bclk) begin
    if (brst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= b_ack;
      ack_s2 <= ack_s1;
    end
  end

  task automatic do_reset(input logic aen_val);
    a_en = aen_val;
    brst = 1'b1;
    repeat (2) @(negedge bclk);
    brst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bvalid !== 1'b1 && n < 10) begin
      @(negedge bclk);
      n++;
    end
    if (bvalid !== 1'b1) chk({name, "_timeout"}, 32'(bvalid), 32'd1);
  endtask

  initial begin
    int bad;
    brst  = 1'b1;
    a_en  = 1'b1;
    adata = 8'h5A;
    bload = 1'b0;

    // Reset held with a_en=1: exactly one capture after release
    repeat (2) @(negedge bclk);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bdata", 32'(bdata), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_berr", 32'(berr), 32'd0);
    chk("rst_bcnt", 32'(bcnt), 32'd0);
    captures = 0;
    brst = 1'b0;
    @(negedge bclk);
    chk("rel_e1_bvalid", 32'(bvalid), 32'd0);
    @(negedge bclk);
    chk("rel_e2_bvalid", 32'(bvalid), 32'd0);
    @(negedge bclk);
    chk("rel_e3_bvalid", 32'(bvalid), 32'd1);
    chk("rel_e3_bdata", 32'(bdata), 32'h5A);
    repeat (6) @(negedge bclk);
    chk("rel_one_capture", 32'(captures), 32'd1);
    bload = 1'b1;
    @(negedge bclk);
    bload = 1'b0;
    chk("rel_consume_bvalid", 32'(bvalid), 32'd0);
    chk("rel_consume_bcnt", 32'(bcnt), 32'd1);

    // Single transfer with exact latency
    do_reset(1'b0);
    a_en  = 1'b1;
    adata = 8'hA5;
    @(negedge bclk);
    @(negedge bclk);
    chk("st_e2_bvalid", 32'(bvalid), 32'd0);
    @(negedge bclk);
    chk("st_e3_bvalid", 32'(bvalid), 32'd1);
    chk("st_e3_bdata", 32'(bdata), 32'hA5);
    @(negedge bclk);
    bload = 1'b1;
    @(negedge bclk);
    bload = 1'b0;
    chk("st_e5_bvalid", 32'(bvalid), 32'd0);
    chk("st_e5_b_ack", 32'(b_ack), 32'd1);
    chk("st_e5_bcnt", 32'(bcnt), 32'd1);

    // Hold for 20 cycles, then bload while empty
    a_en  = 1'b0;
    adata = 8'hB7;
    wait_valid("hold");
    repeat (20) @(negedge bclk);
    chk("hold_bdata", 32'(bdata), 32'hB7);
    chk("hold_bvalid", 32'(bvalid), 32'd1);
    chk("hold_b_ack", 32'(b_ack), 32'd1);
    chk("hold_bcnt", 32'(bcnt), 32'd1);
    bload = 1'b1;
    @(negedge bclk);
    chk("hold_consume_b_ack", 32'(b_ack), 32'd0);
    chk("hold_consume_bcnt", 32'(bcnt), 32'd2);
    repeat (5) @(negedge bclk);
    bload = 1'b0;
    chk("empty_load_b_ack", 32'(b_ack), 32'd0);
    chk("empty_load_bcnt", 32'(bcnt), 32'd2);
    chk("empty_load_bvalid", 32'(bvalid), 32'd0);

    // Violation without and with bload in the pulse cycle
    do_reset(1'b0);
    a_en  = 1'b1;
    adata = 8'h11;
    wait_valid("viol");
    chk("viol_hold_bdata", 32'(bdata), 32'h11);
    a_en  = 1'b0;
    adata = 8'h22;
    repeat (5) @(negedge bclk);
    chk("viol1_berr", 32'(berr), 32'd1);
    chk("viol1_bdata", 32'(bdata), 32'h11);
    chk("viol1_bvalid", 32'(bvalid), 32'd1);
    a_en = 1'b1;
    @(negedge bclk);
    @(negedge bclk);
    bload = 1'b1;
    @(negedge bclk);
    bload = 1'b0;
    chk("viol2_bvalid", 32'(bvalid), 32'd0);
    chk("viol2_berr", 32'(berr), 32'd1);
    chk("viol2_bcnt", 32'(bcnt), 32'd1);
    repeat (4) @(negedge bclk);
    chk("viol2_dropped_bvalid", 32'(bvalid), 32'd0);
    chk("viol2_sticky_berr", 32'(berr), 32'd1);
    do_reset(1'b0);
    chk("viol_rst_berr", 32'(berr), 32'd0);

    // Stream of 300 words with bload tied high and ack round trip
    rx.delete();
    ack_toggles = 0;
    bload = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int n;
      adata = DW'(i);
      a_en  = ~a_en;
      n = 0;
      do begin
        @(negedge bclk);
        n++;
      end while (ack_s2 !== a_en && n < 64);
      if (ack_s2 !== a_en) begin
        chk("stream_ack_timeout", 32'(ack_s2), 32'(a_en));
        break;
      end
    end
    repeat (4) @(negedge bclk);
    bload = 1'b0;
    chk("stream_bcnt", 32'(bcnt), 32'd44);
    chk("stream_ack_toggles", 32'(ack_toggles), 32'd300);
    chk("stream_berr", 32'(berr), 32'd0);
    chk("stream_rx_count", 32'(rx.size()), 32'd300);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== DW'(i)) bad++;
    chk("stream_order_errors", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmcp_recv.md
# bmcp_recv

Receive-side half of the multi-cycle-path (MCP) clock-domain crossing. It sits in the destination (b) clock domain directly downstream of the a-domain MCP sender. It synchronizes the sender's toggle enable, captures the stable data bus into a b-domain register, and presents it to the consumer with a valid/load handshake. On consumption it returns a toggle acknowledge, which the sender synchronizes back as its ack input.

## Interface
- DW, default 8: data width; must match sender.
- SYNC_STAGES, default 2: synchronizer depth for a_en; legal values ≥ 2.
- bclk  input  1  b-domain clock; all flops on rising edge.
- brst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- adata  input  DW  data bus from sender (a domain); stable whenever a_en is stable.
- a_en  input  1  toggle enable from sender (a domain); each transition announces one new word.
- bload  input  1  consumer accepts the current word; honoured only while bvalid=1.
- bdata  output  DW  captured word, held stable while bvalid=1.
- bvalid  output  1  bdata holds an unconsumed word.
- b_ack  output  1  toggle acknowledge to sender; one transition per consumed word.
- berr  output  1  sticky protocol-violation flag.
- bcnt  output  8  count of words consumed, modulo 256.

## Operation
- Synchronizer: a_en → SYNC_STAGES-flop chain → one extra history flop. Pulse bpulse = last sync stage XOR history flop. One bpulse cycle per a_en transition.
- FSM, two states, registered:
  - EMPTY (bvalid=0): on bpulse, bdata <= adata, go VALID. bload is ignored: no ack, no count.
  - VALID (bvalid=1): on bload, go EMPTY, toggle b_ack, bcnt <= bcnt+1 (wraps 255→0). Without bload, remain VALID and hold bdata.
- Protocol violation: bpulse while in VALID, including the same cycle as bload. Set berr=1 (sticky until brst). Drop the arriving word; bdata is unchanged. bload in that cycle is still honoured normally, so the next state is EMPTY.
- adata is sampled only in the bpulse cycle. The sender guarantees that adata is stable from its a_en toggle until the next toggle. Only a_en passes through synchronizer flops; adata is never synchronized.
- Reset values: bdata=0, bvalid=0, b_ack=0, berr=0, bcnt=0. All synchronizer and history flops reset to 0, matching the sender's a_en reset value of 0. The state after reset is EMPTY.
- Reset mid-operation: any in-flight or held word is discarded. Both domains must be reset together; the block does not recover a half-transferred word.

## Timing
- Capture latency: if a_en changes before bclk edge 1, the first sync flop takes the new value at edge 1. bpulse is high during the cycle after edge SYNC_STAGES. bvalid=1 and bdata are valid after edge SYNC_STAGES+1. With the default, bvalid rises at edge 3.
- bpulse is exactly one cycle wide.
- Consume: bload=1 with bvalid=1 sampled at edge n causes bvalid=0, b_ack to toggle, and bcnt to increment, all after edge n. There is no combinational path from bload to any output.
- Back-to-back words: the earliest next capture is gated only by the sender's ack round trip. The block accepts a new bpulse in the cycle immediately after bvalid falls.
- bload held high continuously consumes each word in the cycle after it becomes valid, giving a one-cycle bvalid pulse per word.
- All outputs are registered.

## Test plan
- Reset: assert brst for 2 cycles while a_en=1. Required: all outputs 0 after reset, and no spurious bpulse or bvalid on the first release cycle (the sync chain reloads from 0 and detects the level 1 as one toggle only if a_en differs from 0; the bench checks exactly one capture).
- Single transfer: adata=8'hA5, toggle a_en 0→1. Required: bvalid=1 and bdata=8'hA5 at edge 3. With bload=1 at edge 5: bvalid=0, b_ack=1, and bcnt=1 after edge 5.
- Hold: the word is valid and bload stays 0 for 20 cycles. Required: bdata and bvalid stable, b_ack unchanged, bcnt unchanged. bload=1 while EMPTY produces no ack toggle.
- Stream: 300 words 0..299 (mod 256) with bload tied high and the sender model returning ack through a 2-flop sync. Required: words received in order, b_ack toggles 300 times, bcnt wraps to 44, berr=0.
- Violation: while VALID holding 8'h11, toggle a_en with adata=8'h22 and bload=0. Required: berr=1, bdata stays 8'h11, bvalid stays 1. Repeat with bload=1 in the bpulse cycle. Required: the word is consumed, the state becomes EMPTY, 8'h22 is dropped, and berr stays set until brst.
